// File: rtl/pipe_credit_buffer.sv
// Credit-gated output FIFO for a non-stalling fixed-latency pipeline tail.
// Define PIPE_CREDIT_BUFFER_OVF_CHK_EN to add the sticky ovf_err output.
module pipe_credit_buffer #(
    parameter int DATA  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_req,
    output logic            issue_gnt,
    input  logic            pipe_valid,
    input  logic [DATA-1:0] pipe_data,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    input  logic            out_ready,
    output logic [6:0]      credits
`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
    ,
    output logic            ovf_err
`endif
);

    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
    localparam logic [6:0]     FULL = 7'(DEPTH);

    logic [DATA-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [6:0]      r_cnt;
    logic [6:0]      r_credits;
    logic [DATA-1:0] r_out_data;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_fire;
    logic [PW-1:0]   w_rptr_nxt;
    logic [6:0]      w_cnt_nxt;
    logic            w_head_is_new;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign issue_gnt  = (r_credits != 7'd0);
    assign credits    = r_credits;
    assign out_valid  = (r_cnt != 7'd0);
    assign out_data   = r_out_data;

    assign w_full     = (r_cnt == FULL);
    assign w_pop      = out_valid & out_ready;
    assign w_push     = pipe_valid & (~w_full | w_pop);
    assign w_fire     = issue_req & issue_gnt;
    assign w_rptr_nxt = w_pop ? ptr_inc(r_rptr) : r_rptr;
    assign w_cnt_nxt  = r_cnt + {6'b0, w_push} - {6'b0, w_pop};
    // The new word becomes the head only when it lands in the slot the read pointer moves to.
    assign w_head_is_new = w_push & (w_rptr_nxt == r_wptr);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= pipe_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_credits  <= FULL;
            r_out_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            r_rptr    <= w_rptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_credits <= r_credits - {6'b0, w_fire} + {6'b0, w_pop};
            // Registered head keeps out_data free of any combinational path from pipe_*.
            if (w_cnt_nxt != 7'd0) begin
                r_out_data <= w_head_is_new ? pipe_data : r_mem[w_rptr_nxt];
            end
        end
    end

`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else begin
            // Second term only fires if the grant is ever overridden outside this block.
            r_ovf <= r_ovf | (pipe_valid & w_full & ~w_pop) | (w_fire & (r_credits == 7'd0));
        end
    end

    assign ovf_err = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Randomized and directed bench for pipe_credit_buffer, four instances of different depths
// checked cycle by cycle against a queue-based reference model.
module tb_pipe_credit_buffer;

    localparam int N = 4;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    logic        clk;
    logic        rst_n;
    logic        issue_req  [N];
    logic        issue_gnt  [N];
    logic        pipe_valid [N];
    logic [31:0] pipe_data  [N];
    logic        out_valid  [N];
    logic [31:0] out_data   [N];
    logic        out_ready  [N];
    logic [6:0]  credits    [N];
`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
    logic        ovf_err    [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipe_credit_buffer #(.DATA(32), .DEPTH(dep_of(g))) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .issue_req  (issue_req[g]),
            .issue_gnt  (issue_gnt[g]),
            .pipe_valid (pipe_valid[g]),
            .pipe_data  (pipe_data[g]),
            .out_valid  (out_valid[g]),
            .out_data   (out_data[g]),
            .out_ready  (out_ready[g]),
            .credits    (credits[g])
`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
            ,
            .ovf_err    (ovf_err[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] mq[$];
    int          due_cyc[$];
    logic [31:0] due_dat[$];
    logic [31:0] dout[$];
    int          mcred;
    bit          movf;
    int          lat;
    int          cyc;
    int          nissued;
    logic [31:0] nxt;
    int          gcount;
    int          mincred;
    bit          last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int d, input int l);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            issue_req[i]  = 1'b0;
            pipe_valid[i] = 1'b0;
            pipe_data[i]  = '0;
            out_ready[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        due_cyc.delete();
        due_dat.delete();
        dout.delete();
        mcred   = dep_of(d);
        movf    = 1'b0;
        lat     = l;
        cyc     = 0;
        nissued = 0;
        gcount  = 0;
        mincred = 127;
        @(posedge clk);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the reference model.
    task automatic cycle(input int d, input bit req, input bit rdy,
                         input bit raw, input bit rv, input logic [31:0] rd);
        bit          fire;
        bit          pop;
        bit          pv;
        bit          push;
        logic [31:0] pd;
        @(negedge clk);
        chk("credits", 32'(credits[d]), 32'(mcred & 127));
        chk("issue_gnt", 32'(issue_gnt[d]), 32'(mcred != 0));
        chk("out_valid", 32'(out_valid[d]), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", out_data[d], mq[0]);
`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
        chk("ovf_err", 32'(ovf_err[d]), 32'(movf));
`endif
        last_pop = out_valid[d] && rdy;
        if (last_pop) dout.push_back(out_data[d]);
        if (issue_gnt[d] && req) gcount++;
        if (int'(credits[d]) < mincred) mincred = int'(credits[d]);

        pv = 1'b0;
        pd = '0;
        if (raw) begin
            pv = rv;
            pd = rd;
        end else if (due_cyc.size() != 0 && due_cyc[0] == cyc) begin
            pv = 1'b1;
            pd = due_dat[0];
            void'(due_cyc.pop_front());
            void'(due_dat.pop_front());
        end
        issue_req[d]  = req;
        out_ready[d]  = rdy;
        pipe_valid[d] = pv;
        pipe_data[d]  = pd;

        fire = req && (mcred != 0);
        pop  = rdy && (mq.size() != 0);
        push = pv && ((mq.size() < dep_of(d)) || pop);
        if (pv && !push) movf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(pd);
        if (fire) begin
            due_cyc.push_back(cyc + lat);
            due_dat.push_back(nxt);
            nxt++;
            nissued++;
        end
        mcred = (mcred - int'(fire) + int'(pop)) & 127;
        cyc++;
        @(posedge clk);
    endtask

    task automatic chk_seq(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (idx < dout.size()) ? dout[idx] : 'x;
        chk($sformatf("%s[%0d]", tag, idx), obs, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        nxt   = '0;

        // Reset values on every instance
        do_reset(0, 3);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_credits%0d", i), 32'(credits[i]), 32'(dep_of(i)));
            chk($sformatf("rst_gnt%0d", i), 32'(issue_gnt[i]), 32'd1);
            chk($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
            chk($sformatf("rst_data%0d", i), out_data[i], 32'd0);
        end

        // Credit exhaustion and return: DEPTH=4, latency 3
        nxt = 32'hA0;
        repeat (6) cycle(0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) cycle(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("exh_grants", 32'(gcount), 32'd4);
        #1;
        chk("exh_credits", 32'(credits[0]), 32'd0);
        chk("exh_gnt", 32'(issue_gnt[0]), 32'd0);
        chk("exh_valid", 32'(out_valid[0]), 32'd1);
        repeat (6) cycle(0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("exh_count", 32'(dout.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_seq("exh_word", i, 32'hA0 + 32'(i));

        // Streaming: DEPTH=8, latency 5, consumer always ready
        do_reset(1, 5);
        nxt = '0;
        begin
            int  bubbles;
            bit  seen;
            bubbles = 0;
            seen    = 1'b0;
            for (int k = 0; k < 400 && dout.size() < 100; k++) begin
                cycle(1, nissued < 100, 1'b1, 1'b0, 1'b0, '0);
                if (last_pop) seen = 1'b1;
                else if (seen && dout.size() < 100) bubbles++;
            end
            chk("stream_count", 32'(dout.size()), 32'd100);
            for (int i = 0; i < 100; i++) chk_seq("stream_word", i, 32'(i));
            chk("stream_bubbles", 32'(bubbles), 32'd0);
            chk("stream_mincred_ge2", 32'(mincred >= 2), 32'd1);
        end

        // Pointer wrap: DEPTH=5, random issue and random consumer
        do_reset(2, 2);
        nxt = 32'h100;
        for (int k = 0; k < 400 && dout.size() < 13; k++) begin
            bit rq;
            bit rr;
            rq = ($urandom_range(0, 1) != 0) && (nissued < 13);
            rr = ($urandom_range(0, 1) != 0);
            cycle(2, rq, rr, 1'b0, 1'b0, '0);
        end
        chk("wrap_count", 32'(dout.size()), 32'd13);
        for (int i = 0; i < 13; i++) chk_seq("wrap_word", i, 32'h100 + 32'(i));

        // Simultaneous push and pop while full: DEPTH=2
        do_reset(3, 1);
        cycle(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11);
        cycle(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22);
        cycle(3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33);
        repeat (3) cycle(3, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("pp_count", 32'(dout.size()), 32'd3);
        chk_seq("pp_word", 0, 32'h11);
        chk_seq("pp_word", 1, 32'h22);
        chk_seq("pp_word", 2, 32'h33);

        // Overflow: full, consumer stalled, extra word must be dropped
        do_reset(3, 1);
        cycle(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11);
        cycle(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22);
        cycle(3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44);
        repeat (2) cycle(3, 1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifdef PIPE_CREDIT_BUFFER_OVF_CHK_EN
        #1;
        chk("ovf_set", 32'(ovf_err[3]), 32'd1);
`endif
        repeat (4) cycle(3, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("ovf_count", 32'(dout.size()), 32'd2);
        chk_seq("ovf_word", 0, 32'h11);
        chk_seq("ovf_word", 1, 32'h22);
        do_reset(3, 1);
        repeat (2) cycle(3, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_credit_buffer.md
# pipe_credit_buffer

Output-side elastic buffer for fixed-latency arithmetic pipelines built from `shiftreg` delay lines. The pipeline and its delay lines cannot stall, so this block sits at the pipeline tail: it accepts results arriving a fixed number of cycles after issue and presents them to a downstream consumer with valid/ready backpressure. A credit counter gates issue at the pipeline head so that in-flight plus buffered results never exceed buffer capacity.

## Interface
- `DATA`, 32, result word width in bits.
- `DEPTH`, 16, buffer entries; legal range 1..64, any integer, not restricted to powers of two.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- `issue_req`  in  1  head controller requests to launch one operation into the pipeline.
- `issue_gnt`  out  1  launch permitted this cycle; `issue_fire = issue_req & issue_gnt`.
- `pipe_valid`  in  1  pipeline tail delivers a result this cycle.
- `pipe_data`  in  DATA  result word, sampled when `pipe_valid` is high.
- `out_valid`  out  1  buffer head holds a result.
- `out_data`  out  DATA  buffer head word.
- `out_ready`  in  1  consumer accepts; `pop = out_valid & out_ready`.
- `credits`  out  7  current free credits, for debug and performance counters.

## Operation
- Credit counter: 7 bits, reset value `DEPTH`. Next value = `credits - issue_fire + pop`.
- `issue_gnt = (credits != 0)`, a combinational decode of the credit register only. It does not depend on `issue_req` or `pop` in the same cycle.
- FIFO storage: `DEPTH` entries, with a write pointer, a read pointer, and an occupancy count (0..DEPTH).
- Pointers advance modulo `DEPTH`, wrapping from `DEPTH-1` to 0.
- Push: occurs when `pipe_valid` is high and the FIFO is not full, or when it is full and `pop` occurs in the same cycle.
- Pop: when `pop` is high, the read pointer advances and occupancy decrements.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Full and `pipe_valid` without `pop`: this is a protocol violation by upstream. The word is dropped and FIFO state is unchanged (see Configuration).
- Empty: `out_valid` is 0. `out_data` holds the last value read and is don't-care for checking.
- First-word-fall-through: `out_data` is always the entry at the read pointer.
- The block does not check pipeline latency. Correctness requires exactly one `pipe_valid` per `issue_fire`.

## Timing
- Reset values: `issue_gnt` = 1 (for DEPTH ≥ 1), `credits` = DEPTH, `out_valid` = 0, `out_data` = 0, pointers and occupancy = 0.
- Push-to-output latency is 1 cycle: a word pushed at edge t has `out_valid` = 1 and `out_data` = that word after edge t. There is no combinational `pipe_*` to `out_*` path.
- Credit return latency is 1 cycle. A `pop` at edge t raises `credits` after edge t, so `issue_gnt` can reassert in cycle t+1.
- With `credits` = 0 and `pop` in the same cycle, `issue_gnt` stays 0 in that cycle.
- Sustained throughput is one word per cycle when `out_ready` is held high and `DEPTH` ≥ pipeline latency + 2.
- Reset assertion mid-stream discards buffered words and in-flight credit accounting. The pipeline's `shiftreg` stages share the same reset, so no stale `pipe_valid` arrives afterwards.

## Configuration
- `PIPE_CREDIT_BUFFER_OVF_CHK_EN`
- Defined: adds output `ovf_err` (1 bit, reset 0). It is sticky and set on any push attempt while full without `pop`, or on any `issue_fire` while `credits` = 0 (unreachable unless `issue_gnt` is overridden). It clears only on reset.
- Not defined: the port and its logic are absent. Overflow drops the word silently, with identical FIFO behaviour.

## Test plan
- **Reset values.** DEPTH=4; hold `reset` = 0 for 3 cycles, then release. Expect `credits` = 4, `issue_gnt` = 1, `out_valid` = 0.
- **Credit exhaustion and return.** DEPTH=4, pipeline latency 3, `out_ready` = 0. Hold `issue_req` = 1 for 6 cycles. Expect exactly 4 grants, `credits` = 0, and `issue_gnt` = 0 from cycle 4 onward. Four words 0xA0..0xA3 are buffered. Raise `out_ready`: expect the words in order 0xA0..0xA3, and `issue_gnt` = 1 in the cycle after the first pop.
- **Streaming.** DEPTH=8, latency 5, `out_ready` = 1. Issue 100 sequential words 0..99. Expect `out_data` 0..99 in order with no bubbles after the first arrival. `credits` never drops below 2.
- **Pointer wrap.** DEPTH=5 (not a power of two). Push and pop 13 words with random `out_ready`. Expect order preserved across wrap and occupancy never exceeding 5.
- **Simultaneous push and pop while full.** DEPTH=2, FIFO full with 0x11 and 0x22. In one cycle drive `pipe_valid` with 0x33 and `out_ready` = 1. Expect 0x11 popped, 0x33 accepted, then 0x22 and 0x33 output in order, and `ovf_err` = 0.
- **Overflow (macro defined).** DEPTH=2, FIFO full, `out_ready` = 0; force `pipe_valid` with 0x44. Expect 0x44 dropped, contents still 0x11 and 0x22, and `ovf_err` = 1 until reset.
